// File: rtl/instr_dispatcher.sv
// instr_dispatcher
// ----------------
// Instruction queue and sequencer placed in front of the matrix FSM. Host
// instructions are buffered in a FIFO and issued to the FSM one at a time.
// The full instruction is presented for exactly one cycle. After that the
// DD/AA bits are held stable with the opcode masked to NOP, until the FSM
// drops busy.
//
// Optional feature macro: DISPATCH_TIMEOUT_EN
//   When defined, the dispatcher waits at most TIMEOUT cycles in WAIT_ACK for
//   fsm_busy to rise. On expiry it sets the sticky timeout_err flag, drops the
//   instruction and returns to IDLE. When undefined, WAIT_ACK waits
//   indefinitely and timeout_err is tied low.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-high reset
//   host_instr      in   [7:6] DD, [5:4] AA, [3:0] opcode
//   host_valid      in   host_instr valid
//   host_ready      out  FIFO can accept (= !queue_full)
//   fsm_busy        in   busy output of the matrix FSM
//   fsm_instruction out  drives the FSM host_instruction input
//   queue_count     out  entries currently buffered
//   queue_empty     out  queue_count == 0
//   queue_full      out  queue_count == DEPTH
//   idle            out  queue empty, dispatcher in IDLE, fsm_busy low
//   issued          out  one-cycle pulse while an instruction is presented
//   timeout_err     out  sticky timeout flag (optional feature, else 0)
//   dbg_state       out  current dispatcher state (IDLE/ISSUE/WAIT_ACK/WAIT_DONE)
//
// Handshake: a host transfer happens at a rising edge where host_valid and
// host_ready are both high. host_ready depends only on registered state, so
// it never combinationally depends on host_valid. An accepted NOP
// (opcode[3:2] == 2'b00) completes the handshake but is not enqueued.

module instr_dispatcher #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        host_instr,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              fsm_busy,
  output logic [7:0]        fsm_instruction,
  output logic [ADDR_W:0]   queue_count,
  output logic              queue_empty,
  output logic              queue_full,
  output logic              idle,
  output logic              issued,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  if (DEPTH != (1 << ADDR_W) || DEPTH < 2) begin : g_bad_depth
    $error("instr_dispatcher: DEPTH must be 2**ADDR_W and >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("instr_dispatcher: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        held;
  logic              push_en, pop_en;
  logic              to_fire;

  assign queue_count = count;
  assign queue_empty = (count == '0);
  assign queue_full  = (count == FULL_CNT);
  assign host_ready  = !queue_full;
  assign dbg_state   = state;
  assign idle        = queue_empty && (state == S_IDLE) && !fsm_busy;

  // NOP opcodes complete the handshake without occupying a FIFO slot.
  assign push_en = host_valid && host_ready && (host_instr[3:2] != 2'b00);
  assign pop_en  = (state == S_IDLE) && !queue_empty && !fsm_busy;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= host_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      held   <= 8'h00;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        held   <= mem[rd_ptr];
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- optional WAIT_ACK timeout ----------------
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_err;

  // Fires on the TIMEOUT-th consecutive WAIT_ACK cycle without busy.
  assign to_fire     = (state == S_WAIT_ACK) && !fsm_busy &&
                       (to_cnt == TO_W'(TIMEOUT - 1));
  assign timeout_err = to_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state == S_WAIT_ACK) to_cnt <= to_cnt + 1'b1;
      else                     to_cnt <= '0;
      if (to_fire) to_err <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (pop_en) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (fsm_busy)     state_nxt = S_WAIT_DONE;
        else if (to_fire) state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!fsm_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Outside ISSUE the opcode is masked to NOP so the FSM cannot re-execute,
  // while DD/AA stay valid for the FSM's combinational operand muxes. Both
  // state and held reset asynchronously, so the output drops to 8'h00 at once.
  always_comb begin
    fsm_instruction = {held[7:4], 4'b0000};
    issued          = 1'b0;
    if (state == S_ISSUE) begin
      fsm_instruction = held;
      issued          = 1'b1;
    end
  end

endmodule
